// File: rtl/instr_loader.sv
// instr_loader: valid/ready fill stage that streams words into sequential instruction-buffer slots.
// Optional LOADER_PARITY_EN adds even-parity checking of each accepted word (in_parity/parity_err).
module instr_loader #(
  parameter int Instr_word_size = 32,
  parameter int bs = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req,
  input  logic                       in_valid,
  input  logic [Instr_word_size-1:0] in_data,
`ifdef LOADER_PARITY_EN
  input  logic                       in_parity,
  output logic                       parity_err,
`endif
  output logic                       in_ready,
  output logic [$clog2(bs)-1:0]      buffer_index,
  output logic [Instr_word_size-1:0] Instr_in,
  output logic                       load_done,
  output logic [$clog2(bs):0]        word_count,
  output logic                       full_flag
);
  localparam int AW = $clog2(bs);
  localparam logic [AW-1:0] LAST = AW'(bs - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, buffer_index_q, buffer_index_d;
  logic [Instr_word_size-1:0] instr_q, instr_d;
  logic [AW:0] word_count_q, word_count_d;
  logic full_q, full_d, in_ready_q, in_ready_d, load_done_q, load_done_d;
  logic acc, start, last, bad, perr_q, perr_d;
  assign acc   = in_valid && in_ready_q;
  assign start = load_req && state_q != LOAD;
  assign last  = wr_ptr_q == LAST;
`ifdef LOADER_PARITY_EN
  assign bad        = (^in_data) != in_parity;
  assign parity_err = perr_q;
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      buffer_index_q <= '0;
      instr_q        <= '0;
      word_count_q   <= '0;
      full_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      load_done_q    <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      buffer_index_q <= buffer_index_d;
      instr_q        <= instr_d;
      word_count_q   <= word_count_d;
      full_q         <= full_d;
      in_ready_q     <= in_ready_d;
      load_done_q    <= load_done_d;
      perr_q         <= perr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD)
      state_d = (acc && (in_data == '0 || last || bad)) ? DONE : LOAD;
    else if (load_req)
      state_d = LOAD;
  end
  // Handshake flags are registered from the next state so they line up with state_q.
  always_comb begin
    in_ready_d     = state_d == LOAD;
    load_done_d    = state_d == DONE;
    wr_ptr_d       = start ? '0 : (acc && !last) ? wr_ptr_q + AW'(1) : wr_ptr_q;
    word_count_d   = start ? '0 : acc ? word_count_q + (AW+1)'(1) : word_count_q;
    full_d         = start ? 1'b0 : (acc && last) ? 1'b1 : full_q;
    perr_d         = start ? 1'b0 : (acc && bad) ? 1'b1 : perr_q;
    buffer_index_d = acc ? wr_ptr_q : buffer_index_q;
    instr_d        = acc ? in_data : instr_q;
  end
  assign in_ready     = in_ready_q;
  assign load_done    = load_done_q;
  assign buffer_index = buffer_index_q;
  assign Instr_in     = instr_q;
  assign word_count   = word_count_q;
  assign full_flag    = full_q;
endmodule
